// File: rtl/operand_mem_fetch.sv
// Fetches up to two 64-bit memory operands over the dCache bus: >=3 cycles for one operand, >=5 for two, 1 with none.
// Holds the upstream stage via stallOnMemoryRdOut while busy; results are held in DONE until consumeIn.
module operand_mem_fetch #(
  parameter logic [12:0] READ_TAG = 13'b0_1_1_0000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        canFetchIn,
  input  logic        killIn,
  input  logic        consumeIn,
  input  logic        isMemoryAccessSrc1In,
  input  logic        isMemoryAccessSrc2In,
  input  logic [63:0] memoryAddressSrc1In,
  input  logic [63:0] memoryAddressSrc2In,
  input  logic [31:0] core_memaccess_inprogress_in,
  output logic [31:0] core_memaccess_inprogress_out,
  output logic        reqcyc,
  output logic [63:0] req,
  output logic [12:0] reqtag,
  input  logic        reqack,
  input  logic        respcyc,
  input  logic [63:0] resp,
  output logic        respack,
  output logic [63:0] memoryDataSrc1Out,
  output logic [63:0] memoryDataSrc2Out,
  output logic        fetchDoneOut,
  output logic        stallOnMemoryRdOut
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ1,
    S_RESP1,
    S_REQ2,
    S_RESP2,
    S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic        killed_q, killed_d;
  logic        mem1_q, mem1_d;
  logic        mem2_q, mem2_d;
  logic [63:0] addr1_q, addr1_d;
  logic [63:0] addr2_q, addr2_d;
  logic [63:0] data1_q, data1_d;
  logic [63:0] data2_q, data2_d;
  logic [31:0] flag_q, flag_d;

  logic start;
  logic kill_eff;
  logic busy_q;
  logic busy_d;

  assign start    = canFetchIn && !killIn;
  assign kill_eff = killed_q || killIn;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      killed_q <= 1'b0;
      mem1_q   <= 1'b0;
      mem2_q   <= 1'b0;
      addr1_q  <= 64'd0;
      addr2_q  <= 64'd0;
      data1_q  <= 64'd0;
      data2_q  <= 64'd0;
      flag_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      killed_q <= killed_d;
      mem1_q   <= mem1_d;
      mem2_q   <= mem2_d;
      addr1_q  <= addr1_d;
      addr2_q  <= addr2_d;
      data1_q  <= data1_d;
      data2_q  <= data2_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    killed_d = killed_q;
    mem1_d   = mem1_q;
    mem2_d   = mem2_q;
    addr1_d  = addr1_q;
    addr2_d  = addr2_q;
    data1_d  = data1_q;
    data2_d  = data2_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          mem1_d  = isMemoryAccessSrc1In;
          mem2_d  = isMemoryAccessSrc2In;
          addr1_d = memoryAddressSrc1In;
          addr2_d = memoryAddressSrc2In;
          if (isMemoryAccessSrc1In) begin
            state_d = S_REQ1;
          end else if (isMemoryAccessSrc2In) begin
            state_d = S_REQ2;
          end else begin
            state_d = S_DONE;
            data1_d = 64'd0;
            data2_d = 64'd0;
          end
        end
      end
      S_REQ1: begin
        if (killIn) killed_d = 1'b1;
        if (reqack) state_d = S_RESP1;
      end
      S_RESP1: begin
        if (killIn) killed_d = 1'b1;
        if (respcyc) begin
          // A killed transaction still drains its response, but nothing is kept.
          if (kill_eff) begin
            state_d = S_IDLE;
          end else begin
            data1_d = resp;
            state_d = mem2_q ? S_REQ2 : S_DONE;
          end
        end
      end
      S_REQ2: begin
        if (killIn) killed_d = 1'b1;
        if (reqack) state_d = S_RESP2;
      end
      S_RESP2: begin
        if (killIn) killed_d = 1'b1;
        if (respcyc) begin
          if (kill_eff) begin
            state_d = S_IDLE;
          end else begin
            data2_d = resp;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (killIn || consumeIn) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) killed_d = 1'b0;
  end

  assign busy_q = (state_q == S_REQ1) || (state_q == S_RESP1) ||
                  (state_q == S_REQ2) || (state_q == S_RESP2);
  assign busy_d = (state_d == S_REQ1) || (state_d == S_RESP1) ||
                  (state_d == S_REQ2) || (state_d == S_RESP2);

  // Flag reads as 1 for every cycle a bus transaction is outstanding.
  assign flag_d = busy_d ? 32'd1 : core_memaccess_inprogress_in;

  always_comb begin
    reqcyc = 1'b0;
    req    = 64'd0;
    reqtag = 13'd0;
    if (state_q == S_REQ1) begin
      reqcyc = 1'b1;
      req    = addr1_q;
      reqtag = READ_TAG;
    end else if (state_q == S_REQ2) begin
      reqcyc = 1'b1;
      req    = addr2_q;
      reqtag = READ_TAG;
    end
  end

  assign respack            = ((state_q == S_RESP1) || (state_q == S_RESP2)) && respcyc;
  assign fetchDoneOut       = (state_q == S_DONE);
  assign stallOnMemoryRdOut = busy_q;
  assign memoryDataSrc1Out  = data1_q;
  assign memoryDataSrc2Out  = data2_q;
  assign core_memaccess_inprogress_out = flag_q;

endmodule

// File: tb/tb_operand_mem_fetch.sv
// Directed bench for operand_mem_fetch: inputs driven 1ns after posedge, outputs checked 2ns after posedge.
module tb_operand_mem_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        canFetchIn, killIn, consumeIn;
  logic        isMemoryAccessSrc1In, isMemoryAccessSrc2In;
  logic [63:0] memoryAddressSrc1In, memoryAddressSrc2In;
  logic [31:0] core_memaccess_inprogress_in, core_memaccess_inprogress_out;
  logic        reqcyc;
  logic [63:0] req;
  logic [12:0] reqtag;
  logic        reqack, respcyc;
  logic [63:0] resp;
  logic        respack;
  logic [63:0] memoryDataSrc1Out, memoryDataSrc2Out;
  logic        fetchDoneOut, stallOnMemoryRdOut;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_mem_fetch dut (
    .clk                           (clk),
    .reset                         (reset),
    .canFetchIn                    (canFetchIn),
    .killIn                        (killIn),
    .consumeIn                     (consumeIn),
    .isMemoryAccessSrc1In          (isMemoryAccessSrc1In),
    .isMemoryAccessSrc2In          (isMemoryAccessSrc2In),
    .memoryAddressSrc1In           (memoryAddressSrc1In),
    .memoryAddressSrc2In           (memoryAddressSrc2In),
    .core_memaccess_inprogress_in  (core_memaccess_inprogress_in),
    .core_memaccess_inprogress_out (core_memaccess_inprogress_out),
    .reqcyc                        (reqcyc),
    .req                           (req),
    .reqtag                        (reqtag),
    .reqack                        (reqack),
    .respcyc                       (respcyc),
    .resp                          (resp),
    .respack                       (respack),
    .memoryDataSrc1Out             (memoryDataSrc1Out),
    .memoryDataSrc2Out             (memoryDataSrc2Out),
    .fetchDoneOut                  (fetchDoneOut),
    .stallOnMemoryRdOut            (stallOnMemoryRdOut)
  );

  task automatic nc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    canFetchIn = 1'b0; killIn = 1'b0; consumeIn = 1'b0;
    isMemoryAccessSrc1In = 1'b0; isMemoryAccessSrc2In = 1'b0;
    memoryAddressSrc1In = 64'd0; memoryAddressSrc2In = 64'd0;
    core_memaccess_inprogress_in = 32'h0000_00A0;
    reqack = 1'b0; respcyc = 1'b0; resp = 64'd0;

    // Reset values
    nc(); nc(); #1;
    chk("rst_reqcyc", 64'(reqcyc), 64'd0);
    chk("rst_req", req, 64'd0);
    chk("rst_reqtag", 64'(reqtag), 64'd0);
    chk("rst_respack", 64'(respack), 64'd0);
    chk("rst_data1", memoryDataSrc1Out, 64'd0);
    chk("rst_data2", memoryDataSrc2Out, 64'd0);
    chk("rst_done", 64'(fetchDoneOut), 64'd0);
    chk("rst_stall", 64'(stallOnMemoryRdOut), 64'd0);
    chk("rst_flag", 64'(core_memaccess_inprogress_out), 64'd0);
    reset = 1'b0;

    // Single src1 operand, minimum latency
    nc(); canFetchIn = 1'b1; isMemoryAccessSrc1In = 1'b1; isMemoryAccessSrc2In = 1'b0;
    memoryAddressSrc1In = 64'h1000; memoryAddressSrc2In = 64'h9999; #1;
    chk("a0_stall", 64'(stallOnMemoryRdOut), 64'd0);
    nc(); canFetchIn = 1'b0; reqack = 1'b1; #1;
    chk("a1_reqcyc", 64'(reqcyc), 64'd1);
    chk("a1_req", req, 64'h1000);
    chk("a1_reqtag", 64'(reqtag), 64'h180);
    chk("a1_stall", 64'(stallOnMemoryRdOut), 64'd1);
    chk("a1_flag", 64'(core_memaccess_inprogress_out), 64'd1);
    nc(); reqack = 1'b0; respcyc = 1'b1; resp = 64'hDEADBEEF_00000001; #1;
    chk("a2_reqcyc", 64'(reqcyc), 64'd0);
    chk("a2_respack", 64'(respack), 64'd1);
    chk("a2_stall", 64'(stallOnMemoryRdOut), 64'd1);
    nc(); respcyc = 1'b0; consumeIn = 1'b1; #1;
    chk("a3_data1", memoryDataSrc1Out, 64'hDEADBEEF_00000001);
    chk("a3_data2", memoryDataSrc2Out, 64'd0);
    chk("a3_done", 64'(fetchDoneOut), 64'd1);
    chk("a3_stall", 64'(stallOnMemoryRdOut), 64'd0);
    chk("a3_respack", 64'(respack), 64'd0);
    chk("a3_flag", 64'(core_memaccess_inprogress_out), 64'h00A0);
    nc(); consumeIn = 1'b0; #1;
    chk("a4_done", 64'(fetchDoneOut), 64'd0);

    // Two operands with acks delayed two cycles each
    nc(); canFetchIn = 1'b1; isMemoryAccessSrc1In = 1'b1; isMemoryAccessSrc2In = 1'b1;
    memoryAddressSrc1In = 64'h2000; memoryAddressSrc2In = 64'h3008; #1;
    nc(); canFetchIn = 1'b0; #1;
    chk("b1_reqcyc", 64'(reqcyc), 64'd1);
    chk("b1_req", req, 64'h2000);
    nc(); #1;
    chk("b2_req", req, 64'h2000);
    chk("b2_reqtag", 64'(reqtag), 64'h180);
    nc(); reqack = 1'b1; #1;
    chk("b3_reqcyc", 64'(reqcyc), 64'd1);
    chk("b3_req", req, 64'h2000);
    nc(); reqack = 1'b0; respcyc = 1'b1; resp = 64'h1111; #1;
    chk("b4_reqcyc", 64'(reqcyc), 64'd0);
    chk("b4_respack", 64'(respack), 64'd1);
    nc(); respcyc = 1'b0; #1;
    chk("b5_reqcyc", 64'(reqcyc), 64'd1);
    chk("b5_req", req, 64'h3008);
    chk("b5_flag", 64'(core_memaccess_inprogress_out), 64'd1);
    nc(); #1;
    chk("b6_req", req, 64'h3008);
    nc(); reqack = 1'b1; #1;
    chk("b7_reqcyc", 64'(reqcyc), 64'd1);
    nc(); reqack = 1'b0; respcyc = 1'b1; resp = 64'h2222; #1;
    chk("b8_done", 64'(fetchDoneOut), 64'd0);
    chk("b8_stall", 64'(stallOnMemoryRdOut), 64'd1);
    nc(); respcyc = 1'b0; #1;
    chk("b9_data1", memoryDataSrc1Out, 64'h1111);
    chk("b9_data2", memoryDataSrc2Out, 64'h2222);
    chk("b9_done", 64'(fetchDoneOut), 64'd1);

    // Hold DONE, then consume together with a new start
    for (int i = 0; i < 3; i++) begin
      nc(); #1;
      chk("hold_done", 64'(fetchDoneOut), 64'd1);
      chk("hold_data1", memoryDataSrc1Out, 64'h1111);
      chk("hold_data2", memoryDataSrc2Out, 64'h2222);
      chk("hold_reqcyc", 64'(reqcyc), 64'd0);
      chk("hold_stall", 64'(stallOnMemoryRdOut), 64'd0);
    end
    nc(); consumeIn = 1'b1; canFetchIn = 1'b1; isMemoryAccessSrc1In = 1'b1;
    isMemoryAccessSrc2In = 1'b0; memoryAddressSrc1In = 64'h4000; #1;
    chk("c13_done", 64'(fetchDoneOut), 64'd1);
    nc(); consumeIn = 1'b0; #1;
    chk("c14_done", 64'(fetchDoneOut), 64'd0);
    chk("c14_reqcyc", 64'(reqcyc), 64'd0);
    chk("c14_stall", 64'(stallOnMemoryRdOut), 64'd0);
    chk("c14_data1", memoryDataSrc1Out, 64'h1111);
    nc(); canFetchIn = 1'b0; reqack = 1'b1; #1;
    chk("c15_reqcyc", 64'(reqcyc), 64'd1);
    chk("c15_req", req, 64'h4000);

    // Reset while in RESP1 with a response pending
    nc(); reqack = 1'b0; respcyc = 1'b1; resp = 64'hBAD; reset = 1'b1; #1;
    chk("r16_stall", 64'(stallOnMemoryRdOut), 64'd1);
    nc(); reset = 1'b0; #1;
    chk("r17_respack", 64'(respack), 64'd0);
    chk("r17_reqcyc", 64'(reqcyc), 64'd0);
    chk("r17_req", req, 64'd0);
    chk("r17_stall", 64'(stallOnMemoryRdOut), 64'd0);
    chk("r17_done", 64'(fetchDoneOut), 64'd0);
    chk("r17_data1", memoryDataSrc1Out, 64'd0);
    chk("r17_data2", memoryDataSrc2Out, 64'd0);
    chk("r17_flag", 64'(core_memaccess_inprogress_out), 64'd0);
    nc(); respcyc = 1'b0; #1;

    // No memory operand
    nc(); canFetchIn = 1'b1; isMemoryAccessSrc1In = 1'b0; isMemoryAccessSrc2In = 1'b0; #1;
    nc(); canFetchIn = 1'b0; #1;
    chk("n1_done", 64'(fetchDoneOut), 64'd1);
    chk("n1_reqcyc", 64'(reqcyc), 64'd0);
    chk("n1_stall", 64'(stallOnMemoryRdOut), 64'd0);
    chk("n1_data1", memoryDataSrc1Out, 64'd0);
    chk("n1_data2", memoryDataSrc2Out, 64'd0);
    nc(); consumeIn = 1'b1; #1;
    chk("n2_done", 64'(fetchDoneOut), 64'd1);
    nc(); consumeIn = 1'b0; #1;
    chk("n3_done", 64'(fetchDoneOut), 64'd0);

    // Preload src1 data with 0x77
    nc(); canFetchIn = 1'b1; isMemoryAccessSrc1In = 1'b1; memoryAddressSrc1In = 64'h7000; #1;
    nc(); canFetchIn = 1'b0; reqack = 1'b1; #1;
    nc(); reqack = 1'b0; respcyc = 1'b1; resp = 64'h77; #1;
    nc(); respcyc = 1'b0; consumeIn = 1'b1; #1;
    chk("p_data1", memoryDataSrc1Out, 64'h77);
    nc(); consumeIn = 1'b0; #1;

    // Kill during RESP1 of a two-operand fetch
    nc(); canFetchIn = 1'b1; isMemoryAccessSrc1In = 1'b1; isMemoryAccessSrc2In = 1'b1;
    memoryAddressSrc1In = 64'h5000; memoryAddressSrc2In = 64'h6000; #1;
    nc(); canFetchIn = 1'b0; reqack = 1'b1; #1;
    chk("k1_req", req, 64'h5000);
    nc(); reqack = 1'b0; killIn = 1'b1; #1;
    chk("k2_reqcyc", 64'(reqcyc), 64'd0);
    chk("k2_respack", 64'(respack), 64'd0);
    chk("k2_stall", 64'(stallOnMemoryRdOut), 64'd1);
    nc(); killIn = 1'b0; #1;
    chk("k3_respack", 64'(respack), 64'd0);
    chk("k3_done", 64'(fetchDoneOut), 64'd0);
    chk("k3_stall", 64'(stallOnMemoryRdOut), 64'd1);
    nc(); #1;
    chk("k4_respack", 64'(respack), 64'd0);
    nc(); respcyc = 1'b1; resp = 64'h55; #1;
    chk("k5_respack", 64'(respack), 64'd1);
    chk("k5_done", 64'(fetchDoneOut), 64'd0);
    nc(); respcyc = 1'b0; #1;
    chk("k6_stall", 64'(stallOnMemoryRdOut), 64'd0);
    chk("k6_reqcyc", 64'(reqcyc), 64'd0);
    chk("k6_done", 64'(fetchDoneOut), 64'd0);
    chk("k6_data1", memoryDataSrc1Out, 64'h77);
    nc(); #1;
    chk("k7_reqcyc", 64'(reqcyc), 64'd0);
    chk("k7_done", 64'(fetchDoneOut), 64'd0);
    chk("k7_data1", memoryDataSrc1Out, 64'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
